// File: rtl/board_input_conditioner_if.sv
// Command handshake between the input conditioner and its command consumer.
// Latency: none (wires only).
// Backpressure: consumer holds cmd_ready low to keep cmd_word pending.
// Signals: cmd_valid/cmd_word driven by the master, cmd_ready driven by the slave.
interface board_input_conditioner_if;
    logic       cmd_valid;
    logic [7:0] cmd_word;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_word,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_word,
        output cmd_ready
    );
endinterface

// File: rtl/board_input_conditioner.sv
// Board input conditioner: synchronizes switches, debounces three buttons and
// turns a button1 press into a one-deep command carrying a switch snapshot.
// Latency: 2 cycles sync; button edges after DB_LIMIT further stable samples.
// Backpressure: one command slot; a button1 press while the slot is full and
// not being drained is dropped and recorded in the sticky o_cmd_overrun flag.
// Optional feature: define INPUT_COND_LONGPRESS_EN to build the long-press
// counters; otherwise o_long_press is tied to zero.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_button_in[2:0]    raw buttons (bit0 = button1)
//   i_switch_in[7:0]    raw switches
//   o_switch_sync       synchronized switches (not debounced)
//   o_btn_level/press/release  debounced level and one-cycle edge pulses
//   o_cmd_overrun       sticky: a button1 press was dropped
//   o_long_press        one-cycle pulse after LONG_LIMIT cycles held
//   cmd_if              command handshake (master side)
module board_input_conditioner #(
    parameter int DB_LIMIT   = 1000000,
    parameter int LONG_LIMIT = 100000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  i_button_in,
    input  logic [7:0]  i_switch_in,
    output logic [7:0]  o_switch_sync,
    output logic [2:0]  o_btn_level,
    output logic [2:0]  o_btn_press,
    output logic [2:0]  o_btn_release,
    output logic        o_cmd_overrun,
    output logic [2:0]  o_long_press,
    board_input_conditioner_if.master cmd_if
);

    localparam int                DB_W    = $clog2(DB_LIMIT + 1);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DB_LIMIT - 1);

    typedef enum logic {S_EMPTY, S_FULL} cmd_state_t;

    logic [2:0]      r_btn_meta, r_btn_sync;
    logic [7:0]      r_sw_meta,  r_sw_sync;
    logic [DB_W-1:0] r_db_cnt [3];
    logic [2:0]      r_btn_level, r_btn_press, r_btn_release;
    cmd_state_t      r_state, w_next_state;
    logic            w_load, w_drop;
    logic [7:0]      r_cmd_word;
    logic            r_cmd_overrun;

    // Two-flop synchronizers for the asynchronous board inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_meta <= '0;
            r_btn_sync <= '0;
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
        end else begin
            r_btn_meta <= i_button_in;
            r_btn_sync <= r_btn_meta;
            r_sw_meta  <= i_switch_in;
            r_sw_sync  <= r_sw_meta;
        end
    end

    // Debounce: count consecutive samples that disagree with the accepted
    // level; the DB_LIMIT-th disagreeing sample flips the level. Any agreeing
    // sample restarts the count, so short glitches never reach the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
            r_btn_level   <= '0;
            r_btn_press   <= '0;
            r_btn_release <= '0;
        end else begin
            r_btn_press   <= '0;
            r_btn_release <= '0;
            for (int i = 0; i < 3; i++) begin
                if (r_btn_sync[i] == r_btn_level[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] >= DB_LAST) begin
                    r_db_cnt[i]      <= '0;
                    r_btn_level[i]   <= ~r_btn_level[i];
                    r_btn_press[i]   <= ~r_btn_level[i];
                    r_btn_release[i] <=  r_btn_level[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Command slot FSM: only button1 presses feed it.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_EMPTY;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (r_btn_press[0]) begin
                    w_load       = 1'b1;
                    w_next_state = S_FULL;
                end
            end
            S_FULL: begin
                // Drain and refill in the same cycle is a reload, not an overrun.
                if (cmd_if.cmd_ready && r_btn_press[0]) begin
                    w_load = 1'b1;
                end else if (cmd_if.cmd_ready) begin
                    w_next_state = S_EMPTY;
                end else if (r_btn_press[0]) begin
                    w_drop = 1'b1;
                end
            end
            default: w_next_state = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_word    <= '0;
            r_cmd_overrun <= 1'b0;
        end else begin
            if (w_load) r_cmd_word    <= r_sw_sync;
            if (w_drop) r_cmd_overrun <= 1'b1;
        end
    end

`ifdef INPUT_COND_LONGPRESS_EN
    localparam int              LP_W    = $clog2(LONG_LIMIT + 1);
    localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_LIMIT);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_LIMIT - 1);

    logic [LP_W-1:0] r_lp_cnt [3];
    logic [2:0]      r_long_press;

    // Hold-time counter saturates at LONG_LIMIT so the pulse fires once per hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) r_lp_cnt[i] <= '0;
            r_long_press <= '0;
        end else begin
            r_long_press <= '0;
            for (int i = 0; i < 3; i++) begin
                if (!r_btn_level[i]) begin
                    r_lp_cnt[i] <= '0;
                end else if (r_lp_cnt[i] != LP_MAX) begin
                    r_lp_cnt[i] <= r_lp_cnt[i] + 1'b1;
                    if (r_lp_cnt[i] == LP_LAST) r_long_press[i] <= 1'b1;
                end
            end
        end
    end

    assign o_long_press = r_long_press;
`else
    assign o_long_press = '0;
`endif

    assign o_switch_sync    = r_sw_sync;
    assign o_btn_level      = r_btn_level;
    assign o_btn_press      = r_btn_press;
    assign o_btn_release    = r_btn_release;
    assign o_cmd_overrun    = r_cmd_overrun;
    assign cmd_if.cmd_valid = (r_state == S_FULL);
    assign cmd_if.cmd_word  = r_cmd_word;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Bench for board_input_conditioner with DB_LIMIT=4, LONG_LIMIT=10.
// Timestamp-based reference model checked every cycle, plus directed
// literal checks for the documented scenarios, then randomized traffic.
module tb_board_input_conditioner;
    localparam int DB = 4;
    localparam int LL = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn = '0;
    logic [7:0] sw  = '0;
    logic [7:0] o_switch_sync;
    logic [2:0] o_btn_level, o_btn_press, o_btn_release, o_long_press;
    logic       o_cmd_overrun;

    int total = 0;
    int bad   = 0;

    board_input_conditioner_if cmd_if ();

    board_input_conditioner #(.DB_LIMIT(DB), .LONG_LIMIT(LL)) dut (
        .clk           (clk),
        .reset         (rst),
        .i_button_in   (btn),
        .i_switch_in   (sw),
        .o_switch_sync (o_switch_sync),
        .o_btn_level   (o_btn_level),
        .o_btn_press   (o_btn_press),
        .o_btn_release (o_btn_release),
        .o_cmd_overrun (o_cmd_overrun),
        .o_long_press  (o_long_press),
        .cmd_if        (cmd_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Inputs are sampled as seen at each edge; synced sample = raw of two edges ago.
    // A level flips once the synced sample has disagreed with it for DB edges
    // in a row, measured as time since the last agreeing edge.
    logic [2:0] m_b1, m_b2, m_lev, m_press, m_rel, m_long;
    logic [7:0] m_s1, m_s2, m_word;
    logic       m_valid, m_ovr, m_init = 1'b0;
    int         cyc = 0;
    int         last_agree [3];
    int         rise_cyc   [3];

    always @(posedge clk) begin
        logic [2:0] np, nr, nl;
        cyc++;
        if (rst) begin
            m_b1 = '0; m_b2 = '0; m_s1 = '0; m_s2 = '0;
            m_lev = '0; m_press = '0; m_rel = '0; m_long = '0;
            m_valid = 1'b0; m_word = '0; m_ovr = 1'b0;
            for (int i = 0; i < 3; i++) begin
                last_agree[i] = cyc;
                rise_cyc[i]   = cyc;
            end
            m_init = 1'b1;
        end else begin
            if (!m_valid) begin
                if (m_press[0]) begin m_word = m_s2; m_valid = 1'b1; end
            end else if (cmd_if.cmd_ready && m_press[0]) m_word = m_s2;
            else if (cmd_if.cmd_ready) m_valid = 1'b0;
            else if (m_press[0]) m_ovr = 1'b1;

            for (int i = 0; i < 3; i++) begin
`ifdef INPUT_COND_LONGPRESS_EN
                nl[i] = m_lev[i] && (cyc == rise_cyc[i] + LL);
`else
                nl[i] = 1'b0;
`endif
                np[i] = 1'b0;
                nr[i] = 1'b0;
                if (m_b2[i] == m_lev[i]) begin
                    last_agree[i] = cyc;
                end else if (cyc - last_agree[i] >= DB) begin
                    np[i] = ~m_lev[i];
                    nr[i] = m_lev[i];
                    m_lev[i] = ~m_lev[i];
                    last_agree[i] = cyc;
                    if (m_lev[i]) rise_cyc[i] = cyc;
                end
            end
            m_press = np; m_rel = nr; m_long = nl;
            m_b2 = m_b1; m_b1 = btn;
            m_s2 = m_s1; m_s1 = sw;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("switch_sync", 32'(o_switch_sync),   32'(m_s2));
            chk("btn_level",   32'(o_btn_level),     32'(m_lev));
            chk("btn_press",   32'(o_btn_press),     32'(m_press));
            chk("btn_release", 32'(o_btn_release),   32'(m_rel));
            chk("long_press",  32'(o_long_press),    32'(m_long));
            chk("cmd_valid",   32'(cmd_if.cmd_valid), 32'(m_valid));
            chk("cmd_word",    32'(cmd_if.cmd_word), 32'(m_word));
            chk("cmd_overrun", 32'(o_cmd_overrun),   32'(m_ovr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
    endtask

    initial begin
        int lp_cnt;
        int lp_at;
        logic [2:0] lp_any;
        cmd_if.cmd_ready = 1'b0;
        do_reset();
        chk("reset_level", 32'(o_btn_level), 0);
        chk("reset_valid", 32'(cmd_if.cmd_valid), 0);
        chk("reset_word",  32'(cmd_if.cmd_word), 0);
        chk("reset_ovr",   32'(o_cmd_overrun), 0);

        // Button1 press with switches at A5, then drained.
        sw = 8'hA5; btn[0] = 1'b1;
        tick(5);
        chk("press_early_level", 32'(o_btn_level[0]), 0);
        tick(1);
        chk("press_level6", 32'(o_btn_level[0]), 1);
        chk("press_pulse6", 32'(o_btn_press[0]), 1);
        tick(1);
        chk("press_pulse7", 32'(o_btn_press[0]), 0);
        chk("cmd_valid_A5", 32'(cmd_if.cmd_valid), 1);
        chk("cmd_word_A5",  32'(cmd_if.cmd_word), 32'hA5);
        cmd_if.cmd_ready = 1'b1;
        tick(1);
        cmd_if.cmd_ready = 1'b0;
        chk("cmd_drained", 32'(cmd_if.cmd_valid), 0);
        chk("word_held",   32'(cmd_if.cmd_word), 32'hA5);
        btn[0] = 1'b0;
        tick(6);
        chk("release_pulse", 32'(o_btn_release[0]), 1);
        chk("release_level", 32'(o_btn_level[0]), 0);
        tick(2);

        // Three-cycle glitch on button2 must not register.
        btn[1] = 1'b1;
        tick(3);
        btn[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk("glitch_quiet", 32'({o_btn_level[1], o_btn_press[1], o_btn_release[1]}), 0);
        end

        // Two presses without ready: first snapshot kept, overrun sticky.
        sw = 8'h11; btn[0] = 1'b1; tick(8); btn[0] = 1'b0; tick(8);
        sw = 8'h22; btn[0] = 1'b1; tick(8); btn[0] = 1'b0; tick(8);
        chk("ovr_word",  32'(cmd_if.cmd_word), 32'h11);
        chk("ovr_valid", 32'(cmd_if.cmd_valid), 1);
        chk("ovr_flag",  32'(o_cmd_overrun), 1);
        cmd_if.cmd_ready = 1'b1; tick(1); cmd_if.cmd_ready = 1'b0;
        tick(5);
        chk("ovr_sticky", 32'(o_cmd_overrun), 1);

        // Button1 held through reset: press DB+2 cycles after reset falls.
        btn[0] = 1'b1;
        do_reset();
        chk("ovr_cleared", 32'(o_cmd_overrun), 0);
        chk("rst_valid",   32'(cmd_if.cmd_valid), 0);
        tick(DB + 2);
        chk("held_press", 32'(o_btn_press[0]), 1);
        tick(1);
        chk("held_load", 32'(cmd_if.cmd_word), 32'h22);
        btn[0] = 1'b0; tick(8);

        // Ready and a new press in the same cycle: reload, no overrun.
        sw = 8'h3C; btn[0] = 1'b1;
        tick(6);
        cmd_if.cmd_ready = 1'b1;
        tick(1);
        cmd_if.cmd_ready = 1'b0;
        chk("reload_valid", 32'(cmd_if.cmd_valid), 1);
        chk("reload_word",  32'(cmd_if.cmd_word), 32'h3C);
        chk("reload_ovr",   32'(o_cmd_overrun), 0);
        cmd_if.cmd_ready = 1'b1; tick(1); cmd_if.cmd_ready = 1'b0;
        chk("reload_drain", 32'(cmd_if.cmd_valid), 0);
        btn[0] = 1'b0; tick(8);

        // Button3 held 30 cycles.
        btn[2] = 1'b1;
        lp_cnt = 0; lp_at = -1; lp_any = '0;
        for (int t = 1; t <= 30; t++) begin
            tick(1);
            lp_any |= o_long_press;
            if (o_long_press[2]) begin
                lp_cnt++;
                lp_at = t;
            end
        end
`ifdef INPUT_COND_LONGPRESS_EN
        chk("long_count", 32'(lp_cnt), 1);
        chk("long_time",  32'(lp_at), 32'(6 + LL));
`else
        chk("long_off", 32'(lp_any), 0);
`endif
        btn[2] = 1'b0; tick(8);

        // Randomized traffic: bouncy phase, then calmer phase reaching long holds.
        for (int k = 0; k < 4000; k++) begin
            int p;
            p = (k < 2000) ? 10 : 45;
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, p - 1) == 0) btn[i] = ~btn[i];
            if ($urandom_range(0, 15) == 0) sw = 8'($urandom);
            cmd_if.cmd_ready = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 599) == 0);
            tick(1);
        end
        rst = 1'b0;
        cmd_if.cmd_ready = 1'b0;
        tick(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/board_input_conditioner.md
BOARD_INPUT_CONDITIONER -- requirements
Module: board_input_conditioner

Interface
REQ-001 Parameter DB_LIMIT, default 1000000, number of consecutive stable samples needed to accept a button change; legal range is DB_LIMIT >= 2.
REQ-002 Parameter LONG_LIMIT, default 100000000, number of cycles a debounced button must stay high to count as a long press.
REQ-003 clk  in  1  system clock.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 button_in  in  3  raw, asynchronous board buttons; bit0=button1, bit1=button2, bit2=button3.
REQ-006 switch_in  in  8  raw, asynchronous board switches.
REQ-007 cmd_ready  in  1  the command consumer accepts cmd_word this cycle.
REQ-008 switch_sync  out  8  synchronized switch value; not debounced.
REQ-009 btn_level  out  3  debounced button level.
REQ-010 btn_press  out  3  one-cycle pulse on each debounced rise.
REQ-011 btn_release  out  3  one-cycle pulse on each debounced fall.
REQ-012 cmd_valid  out  1  cmd_word holds an unconsumed command.
REQ-013 cmd_word  out  8  switch snapshot captured on a button1 press.
REQ-014 cmd_overrun  out  1  sticky flag: a button1 press was dropped.
REQ-015 long_press  out  3  one-cycle long-press pulse per button.

Function
REQ-016 Each button_in bit and each switch_in bit SHALL pass through a 2-FF synchronizer, giving 2 cycles of latency.
REQ-017 Each button SHALL have its own debounce counter, width clog2(DB_LIMIT+1), with these rules:
- Counter clears on any cycle where the synced sample equals btn_level.
- Counter increments while the synced sample differs from btn_level.
- Counter never wraps.
REQ-018 On the edge where the counter is DB_LIMIT-1 and the sample still differs, btn_level SHALL toggle and the counter SHALL clear; this is the DB_LIMIT-th differing sample.
REQ-019 A glitch shorter than DB_LIMIT cycles SHALL leave btn_level, btn_press and btn_release unchanged.
REQ-020 btn_press and btn_release SHALL assert on the same edge that btn_level rises or falls, for exactly one cycle.
REQ-021 The command path SHALL be a 2-state FSM:
- EMPTY: cmd_valid=0.
- FULL: cmd_valid=1.
REQ-022 In EMPTY, btn_press[0] SHALL load cmd_word<=switch_sync and move the FSM to FULL.
REQ-023 In FULL, cmd_ready=1 without btn_press[0] SHALL move the FSM to EMPTY; cmd_word holds its last value.
REQ-024 In FULL, cmd_ready=1 and btn_press[0] in the same cycle SHALL reload cmd_word and stay in FULL, with no overrun.
REQ-025 In FULL, btn_press[0] with cmd_ready=0 SHALL drop the press, leave cmd_word unchanged and set cmd_overrun.
REQ-026 cmd_overrun SHALL clear only on reset.
REQ-027 cmd_word SHALL be stable whenever cmd_valid=1 and no reload is taking place.
REQ-028 btn_press[1] and btn_press[2] SHALL have no effect on the command FSM.

Reset
REQ-029 While reset=1, all of the following SHALL go to 0 on the next clk edge:
- synchronizer flops, debounce counters and long-press counters;
- btn_level, btn_press, btn_release, long_press;
- switch_sync, cmd_valid, cmd_word, cmd_overrun;
- FSM state, which goes to EMPTY.
REQ-030 Reset mid-debounce SHALL discard the partial count.
REQ-031 A button held through reset SHALL produce btn_press DB_LIMIT+2 cycles after reset falls, ±1 cycle.

Configuration
REQ-032 Macro INPUT_COND_LONGPRESS_EN defined: each button has a cycle counter while btn_level=1, cleared when btn_level=0 and saturating at LONG_LIMIT.
REQ-033 With INPUT_COND_LONGPRESS_EN defined, long_press[i] SHALL pulse for one cycle when the counter reaches LONG_LIMIT, once per hold.
REQ-034 Macro INPUT_COND_LONGPRESS_EN undefined: long_press SHALL be constant 0 and no long-press counters are built.

Verification (DB_LIMIT=4, LONG_LIMIT=10)
REQ-035 Raw button1 high at cycle 0 and held -> btn_level[0]=1 and btn_press[0]=1 at cycle 6 ±1, btn_press low the next cycle.
REQ-036 Raw button2 high for 3 cycles then low -> btn_level, btn_press and btn_release all stay 0.
REQ-037 switch_in=8'hA5, then button1 press -> cmd_valid=1 and cmd_word=8'hA5; cmd_ready pulsed -> cmd_valid=0 next cycle.
REQ-038 Two button1 presses with cmd_ready=0 -> cmd_word keeps the first snapshot and cmd_overrun=1 until reset.
REQ-039 cmd_ready and a new press in the same cycle with switch_in=8'h3C -> cmd_valid stays 1, cmd_word=8'h3C, cmd_overrun=0.
REQ-040 INPUT_COND_LONGPRESS_EN defined, button3 held 30 cycles -> exactly one long_press[2] pulse, 10 cycles after btn_level[2] rises; macro undefined -> long_press=0 throughout.
